// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master buttons/LEDs Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS0  = 2'd1,
    BUS1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Ack watchdog: counts strobe cycles without ack; expiry flags the cycle whose count would reach the limit.
// Any cycle that is not counting (idle, stb low, ack) clears the count.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          inc;
  logic [CW-1:0] cnt_q, cnt_d;

  assign inc       = run_i && !ack_i;
  assign cnt_d     = inc ? cnt_q + CW'(1) : '0;
  // Expiry is combinational so the abort lands exactly TIMEOUT_CYCLES after stb rose.
  assign expired_o = inc && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_led_arbiter.sv
// Two-master Wishbone arbiter in front of the buttons/LEDs slave: whole-cycle grants, round-robin on contention,
// one-cycle grant latency, combinational ack/data return, and an ack timeout that aborts with err to the owner.
module wb_led_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,

  output logic [1:0]  grant_o
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       last_grant_q;  // 1 = m1 was granted last, so m0 wins the next tie
  logic       m0_err_q, m1_err_q;
  logic       tmo_run, tmo_expired;

  assign tmo_run = ((state_q == BUS0) && m0_cyc_i && m0_stb_i) ||
                   ((state_q == BUS1) && m1_cyc_i && m1_stb_i);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .run_i     (tmo_run),
    .ack_i     (s_ack_i),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_NONE;
      last_grant_q <= 1'b1;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
            state_q      <= BUS0;
            grant_q      <= GRANT_M0;
            last_grant_q <= 1'b0;
          end else if (m1_cyc_i) begin
            state_q      <= BUS1;
            grant_q      <= GRANT_M1;
            last_grant_q <= 1'b1;
          end
        end
        BUS0: begin
          if (!m0_cyc_i) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
          end else if (tmo_expired) begin
            state_q  <= ABORT;
            m0_err_q <= 1'b1;
          end
        end
        BUS1: begin
          if (!m1_cyc_i) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
          end else if (tmo_expired) begin
            state_q  <= ABORT;
            m1_err_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          grant_q  <= GRANT_NONE;
          m0_err_q <= 1'b0;
          m1_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o  = grant_q;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;

  // Owner's controls pass straight through; everything is quiet in IDLE and ABORT.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    case (state_q)
      BUS0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
      BUS1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_led_arbiter.sv
// Directed bench for wb_led_arbiter (timeout set to 8): arbitration order, block hold, timeout abort, async reset.
module tb_wb_led_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  wb_led_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_ni (wb_rst_ni),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i), .m0_sel_i (m0_sel_i),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m0_dat_o (m0_dat_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i), .m1_sel_i (m1_sel_i),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .m1_dat_o (m1_dat_o),
    .s_cyc_o  (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o), .s_sel_o (s_sel_o),
    .s_adr_o  (s_adr_o), .s_dat_o (s_dat_o), .s_ack_i (s_ack_i), .s_dat_i (s_dat_i),
    .grant_o  (grant_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    wb_rst_ni = 1'b0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'h0; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'h0; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = 32'hDEAD_BEEF;
    #3;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_m0_dat", m0_dat_o, 32'h0);
    chk("rst_m1_err", 32'(m1_err_o), 32'h0);
    tick(); tick();
    wb_rst_ni = 1'b1;
    tick();

    // Round robin: simultaneous requests from reset grant m0, then m1, then m0.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0010; m0_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h3000_0020; m1_sel_i = 4'hF;
    settle(); chk("rr_pre_grant", 32'(grant_o), 32'h0);
    tick(); settle();
    chk("rr1_grant", 32'(grant_o), 32'h1);
    chk("rr1_adr", s_adr_o, 32'h3000_0010);
    s_ack_i = 1; settle();
    chk("rr1_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("rr1_m1_ack", 32'(m1_ack_o), 32'h0);
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; settle();
    chk("rr1_release_gate", 32'(s_cyc_o), 32'h0);
    tick(); settle();
    chk("rr_idle1", 32'(grant_o), 32'h0);
    m0_cyc_i = 1; m0_stb_i = 1;
    tick(); settle();
    chk("rr2_grant", 32'(grant_o), 32'h2);
    chk("rr2_adr", s_adr_o, 32'h3000_0020);
    s_ack_i = 1; settle();
    chk("rr2_m1_ack", 32'(m1_ack_o), 32'h1);
    chk("rr2_m0_ack", 32'(m0_ack_o), 32'h0);
    tick(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; settle();
    tick(); settle();
    chk("rr_idle2", 32'(grant_o), 32'h0);
    m1_cyc_i = 1; m1_stb_i = 1;
    tick(); settle();
    chk("rr3_grant", 32'(grant_o), 32'h1);
    s_ack_i = 1; settle();
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); settle();
    chk("rr_done_idle", 32'(grant_o), 32'h0);

    // m0 single write, slave acks in the third bus cycle.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'h3000_0004; m0_dat_i = 32'h0000_00A5;
    settle(); chk("wr_idle_s_cyc", 32'(s_cyc_o), 32'h0);
    tick(); settle();
    chk("wr_grant", 32'(grant_o), 32'h1);
    chk("wr_s_dat", s_dat_o, 32'h0000_00A5);
    chk("wr_s_adr", s_adr_o, 32'h3000_0004);
    chk("wr_s_we", 32'(s_we_o), 32'h1);
    chk("wr_s_sel", 32'(s_sel_o), 32'hF);
    tick(); settle();
    chk("wr_wait_ack", 32'(m0_ack_o), 32'h0);
    tick(); s_ack_i = 1; settle();
    chk("wr_m0_ack", 32'(m0_ack_o), 32'h1);
    chk("wr_m1_ack", 32'(m1_ack_o), 32'h0);
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; settle();
    chk("wr_ack_one_cycle", 32'(m0_ack_o), 32'h0);
    tick(); settle();
    chk("wr_idle", 32'(grant_o), 32'h0);

    // m1 block of four reads; m0 requests meanwhile and must wait.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h3000_0008;
    tick(); settle();
    chk("blk_grant", 32'(grant_o), 32'h2);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_000C;
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 1; s_dat_i = 32'((i + 1) * 32'h11);
      settle();
      chk("blk_m1_dat", m1_dat_o, 32'((i + 1) * 32'h11));
      chk("blk_m1_ack", 32'(m1_ack_o), 32'h1);
      chk("blk_m0_ack", 32'(m0_ack_o), 32'h0);
      chk("blk_m0_dat", m0_dat_o, 32'h0);
      chk("blk_grant_hold", 32'(grant_o), 32'h2);
      tick();
    end
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; settle();
    chk("blk_drop_grant", 32'(grant_o), 32'h2);
    chk("blk_drop_s_cyc", 32'(s_cyc_o), 32'h0);
    tick(); settle();
    chk("blk_idle_gap", 32'(grant_o), 32'h0);
    tick(); settle();
    chk("blk_m0_after", 32'(grant_o), 32'h1);
    chk("blk_m0_adr", s_adr_o, 32'h3000_000C);
    s_ack_i = 1; settle();
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick();

    // Timeout: no ack for 8 strobe cycles -> err in the 9th cycle of ownership.
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0000;
    tick(); settle();
    chk("tmo_grant", 32'(grant_o), 32'h1);
    chk("tmo_err_c0", 32'(m0_err_o), 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick(); settle();
      chk("tmo_err_early", 32'(m0_err_o), 32'h0);
      chk("tmo_s_cyc_early", 32'(s_cyc_o), 32'h1);
    end
    tick(); s_ack_i = 1; settle();
    chk("tmo_err", 32'(m0_err_o), 32'h1);
    chk("tmo_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("tmo_s_stb", 32'(s_stb_o), 32'h0);
    chk("tmo_late_ack_ignored", 32'(m0_ack_o), 32'h0);
    chk("tmo_m1_err", 32'(m1_err_o), 32'h0);
    tick(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; settle();
    chk("tmo_err_single", 32'(m0_err_o), 32'h0);
    chk("tmo_idle", 32'(grant_o), 32'h0);
    tick();

    // Ack in the expiry cycle wins over the abort.
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ack_i = 1; settle();
    chk("race_ack", 32'(m0_ack_o), 32'h1);
    chk("race_err", 32'(m0_err_o), 32'h0);
    tick(); s_ack_i = 0; settle();
    chk("race_no_abort_err", 32'(m0_err_o), 32'h0);
    chk("race_still_granted", 32'(grant_o), 32'h1);
    chk("race_s_cyc", 32'(s_cyc_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); settle();
    chk("race_idle", 32'(grant_o), 32'h0);

    // Async reset in the middle of an m1 transfer.
    m1_cyc_i = 1; m1_stb_i = 1;
    tick(); settle();
    chk("rst_mid_grant_pre", 32'(grant_o), 32'h2);
    s_ack_i = 1; settle();
    chk("rst_mid_ack_pre", 32'(m1_ack_o), 32'h1);
    wb_rst_ni = 1'b0; settle();
    chk("rst_mid_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_mid_grant", 32'(grant_o), 32'h0);
    chk("rst_mid_m1_ack", 32'(m1_ack_o), 32'h0);
    chk("rst_mid_s_adr", s_adr_o, 32'h0);
    s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick(); wb_rst_ni = 1'b1; settle();
    chk("rst_rel_grant", 32'(grant_o), 32'h0);
    tick(); settle();
    chk("rst_rel_m0_first", 32'(grant_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_led_arbiter.md
# wb_led_arbiter

Two-master Wishbone arbiter that shares the single buttons/LEDs Wishbone slave between the management SoC port and a local user-side requester (pattern engine or button handler). Grants whole bus cycles, with round-robin fairness on contention and a per-transfer ack timeout that aborts a hung access and reports an error to the owning master. Sits in the user analog project wrapper between the Wishbone slave port and the buttons/LEDs peripheral.

## Interface
- TIMEOUT_CYCLES, 255: stb-high cycles without slave ack before abort; legal range 1..65535.
- wb_clk_i  input  1  single clock for all logic.
- wb_rst_ni  input  1  reset, asynchronous assert, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  management master controls.
- m0_sel_i  input  4;  m0_adr_i, m0_dat_i  input  32 each.
- m0_ack_o, m0_err_o  output  1 each;  m0_dat_o  output  32.
- m1_*  same set as m0_*, local requester.
- s_cyc_o, s_stb_o, s_we_o  output  1 each;  s_sel_o  output  4;  s_adr_o, s_dat_o  output  32  to slave.
- s_ack_i  input  1;  s_dat_i  input  32  from slave.
- grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

## Operation
- FSM states: IDLE, BUS0, BUS1, ABORT. Reset state IDLE.
- IDLE: m0_cyc only -> BUS0; m1_cyc only -> BUS1; both -> master not granted last (last_grant flop, reset value 1, so m0 wins first contention). Neither -> stay.
- last_grant updated on every IDLE->BUSx transition.
- BUSx: s_cyc/stb/we/sel/adr/dat driven combinationally from master x, with s_cyc_o = mx_cyc_i and s_stb_o = mx_stb_i. s_ack_i routed only to mx_ack_o; s_dat_i to mx_dat_o. Non-owner ack/err 0, dat_o 0.
- BUSx -> IDLE on the cycle mx_cyc_i is sampled low; owner holds grant across any number of back-to-back strobes while cyc stays high (block transfers).
- Timeout counter, width clog2(TIMEOUT_CYCLES+1): clears in IDLE, on s_ack_i, and when stb low; increments each BUSx cycle with stb high and no ack. Reaching TIMEOUT_CYCLES -> ABORT.
- ABORT (exactly one cycle): mx_err_o = 1 for owner, mx_ack_o = 0, all s_* outputs 0; next state IDLE. Owner must drop cyc; if it keeps cyc high it re-arbitrates normally from IDLE.
- s_ack_i arriving in ABORT or IDLE is ignored.
- No register interface; the arbiter is transparent to addresses.

## Timing
- Reset values: s_cyc_o, s_stb_o, s_we_o 0, s_sel_o 0, s_adr_o/s_dat_o 0, all m*_ack_o/err_o 0, m*_dat_o 0, grant_o 00, counter 0.
- Grant latency: cyc sampled high in IDLE at edge N -> s_cyc_o high during cycle N+1. First-access latency = 1 cycle + slave latency.
- Ack path: s_ack_i -> mx_ack_o combinational, same cycle.
- Release: mx_cyc_i low -> s_cyc_o low same cycle (gating), state IDLE at next edge; minimum one IDLE cycle between two grants.
- Timeout: stb high from edge T with no ack -> err_o asserted in cycle T+TIMEOUT_CYCLES, single cycle.
- Ack in the same cycle the counter would reach TIMEOUT_CYCLES: ack wins, no abort.
- Async reset mid-transfer: all outputs to reset values immediately, FSM IDLE, last_grant 1.

## Structure
- Package wb_arb_pkg: state enum (IDLE, BUS0, BUS1, ABORT), GRANT_NONE/GRANT_M0/GRANT_M1 constants.
- One sub-module: wb_arb_timeout (counter + expiry flag, parameterised by TIMEOUT_CYCLES). FSM and muxing stay in the top.

## Test plan
- m0 single write adr 0x3000_0004 dat 0x0000_00A5, slave acks after 2 cycles -> grant_o 01, s_dat_o 0xA5, m0_ack_o one cycle, m1_ack_o stays 0.
- m0 and m1 assert cyc same edge, three rounds -> grants m0, m1, m0 in order, one IDLE cycle between each.
- m1 block of 4 reads, cyc held high, slave returns 0x11..0x44 -> grant stays 10 throughout, m0 request waits until m1 drops cyc.
- TIMEOUT_CYCLES=8, slave never acks m0 read -> m0_err_o high exactly in cycle 8 after stb, s_cyc_o low that cycle, FSM IDLE next.
- Slave ack arrives in cycle 8 (expiry cycle) -> m0_ack_o 1, m0_err_o 0.
- wb_rst_ni pulsed low mid m1 transfer -> s_cyc_o, grant_o 0 without clock edge; after release simultaneous requests grant m0 first.
